// File: rtl/demux_1_2_4_pkg.sv
// ----------------------------------------------------------------------------
// demux_1_2_4_pkg
//   Shared sizing defaults and lane-addressing helper for the 1-to-N
//   registered demultiplexer.
//   Contents:
//     DEMUX_DATA_W  default lane width
//     DEMUX_SEL_W   default select width
//     DEMUX_N_OUT   default lane count (2**DEMUX_SEL_W)
//     lane_offset() bit offset of lane k within the packed output bus
// ----------------------------------------------------------------------------
package demux_1_2_4_pkg;

    localparam int unsigned DEMUX_DATA_W = 1;
    localparam int unsigned DEMUX_SEL_W  = 2;
    localparam int unsigned DEMUX_N_OUT  = 4;

    // Lane k occupies O[lane_offset(k, w) +: w]; lane 0 is the LSB lane.
    function automatic int unsigned lane_offset(input int unsigned k,
                                                input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_1_2_4_if.sv
// ----------------------------------------------------------------------------
// demux_1_2_4_if
//   Bundles the data/select inputs and the packed lane output of the
//   demultiplexer.
//   Signals:
//     in  DATA_W        data to route
//     S   SEL_W         lane select (0 = LSB lane)
//     O   DATA_W*N_OUT  packed output lanes
//   Modports:
//     master  drives in/S, observes O (producer / testbench side)
//     slave   receives in/S, drives O (demux side)
// ----------------------------------------------------------------------------
interface demux_1_2_4_if
    import demux_1_2_4_pkg::*;
#(
    parameter int unsigned DATA_W = DEMUX_DATA_W,
    parameter int unsigned SEL_W  = DEMUX_SEL_W,
    parameter int unsigned N_OUT  = DEMUX_N_OUT
);

    logic [DATA_W-1:0]       in;
    logic [SEL_W-1:0]        S;
    logic [DATA_W*N_OUT-1:0] O;

    modport master (
        output in,
        output S,
        input  O
    );

    modport slave (
        input  in,
        input  S,
        output O
    );

endinterface

// File: rtl/demux_1_2_4_decoder.sv
// ----------------------------------------------------------------------------
// demux_decoder
//   Combinational binary-to-one-hot decoder.
//   Ports:
//     sel     input   SEL_W  binary lane index
//     onehot  output  N_OUT  bit sel set, all others clear
// ----------------------------------------------------------------------------
module demux_decoder
    import demux_1_2_4_pkg::*;
#(
    parameter int unsigned SEL_W = DEMUX_SEL_W,
    parameter int unsigned N_OUT = DEMUX_N_OUT
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (sel == SEL_W'(k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1_2_4.sv
// ----------------------------------------------------------------------------
// demux_1_2_4
//   1-to-N demultiplexer with registered output. Every cycle the input word
//   is routed to lane S and every other lane is cleared; one cycle latency.
//   Ports:
//     clk  input  1        rising-edge clock
//     rst  input  1        synchronous, active-high reset (clears O)
//     bus  slave           in (DATA_W), S (SEL_W), O (DATA_W*N_OUT)
// ----------------------------------------------------------------------------
module demux_1_2_4
    import demux_1_2_4_pkg::*;
#(
    parameter int unsigned DATA_W = DEMUX_DATA_W,
    parameter int unsigned SEL_W  = DEMUX_SEL_W,
    parameter int unsigned N_OUT  = DEMUX_N_OUT
) (
    input  logic                clk,
    input  logic                rst,
    demux_1_2_4_if.slave        bus
);

    // The select must address exactly the available lanes.
    if (N_OUT != (2 ** SEL_W)) begin : g_bad_lane_count
        $error("demux_1_2_4: N_OUT (%0d) must equal 2**SEL_W (%0d)",
               N_OUT, 2 ** SEL_W);
    end

    logic [N_OUT-1:0]        onehot;
    logic [DATA_W*N_OUT-1:0] gated;

    demux_decoder #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_decoder (
        .sel    (bus.S),
        .onehot (onehot)
    );

    // Each lane is the input ANDed with its decode bit, so unselected
    // lanes are forced to zero without any dependence on the previous O.
    always_comb begin
        gated = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            gated[lane_offset(k, DATA_W) +: DATA_W] = bus.in & {DATA_W{onehot[k]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.O <= '0;
        end else begin
            bus.O <= gated;
        end
    end

    // An unknown select would make the routed lane undefined.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(bus.S))
                else $error("demux_1_2_4: select is X/Z");
        end
    end

endmodule

// File: tb/tb_demux_1_2_4.sv
// ----------------------------------------------------------------------------
// tb_demux_1_2_4
//   Self-checking bench for demux_1_2_4: directed scenarios followed by
//   random in/S/rst traffic, compared against a shift-based reference model.
// ----------------------------------------------------------------------------
module tb_demux_1_2_4;

    logic clk;
    logic rst;

    int unsigned errors = 0;
    int unsigned checks = 0;

    demux_1_2_4_if #(.DATA_W(1), .SEL_W(2), .N_OUT(4)) bus ();

    demux_1_2_4 #(.DATA_W(1), .SEL_W(2), .N_OUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a registered 1-to-4 demux puts `in` at bit position S,
    // or clears everything when reset is sampled.
    function automatic logic [3:0] model(input logic r, input logic i,
                                         input logic [1:0] s);
        logic [3:0] v;
        if (r) return 4'b0000;
        v = 4'(i);
        return v << s;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic r, input logic i,
                        input logic [1:0] s);
        logic [3:0] exp;
        @(negedge clk);
        rst    = r;
        bus.in = i;
        bus.S  = s;
        exp    = model(r, i, s);
        @(posedge clk);
        #1;
        check(tag, bus.O, exp);
    endtask

    initial begin
        logic       r;
        logic       i;
        logic [1:0] s;
        logic [3:0] exp;

        rst    = 1'b1;
        bus.in = 1'b1;
        bus.S  = 2'b10;

        // 1. reset held for two cycles with a live routing request
        step("reset_cycle0", 1'b1, 1'b1, 2'b10);
        step("reset_cycle1", 1'b1, 1'b1, 2'b10);

        // 2. first routed value after reset
        step("lane0_in1", 1'b0, 1'b1, 2'b00);

        // 3. zero input yields all-zero output
        step("lane0_in0", 1'b0, 1'b0, 2'b00);

        // 4. top lane, then a different lane clears the old one
        step("lane3_in1", 1'b0, 1'b1, 2'b11);
        step("lane1_after_lane3", 1'b0, 1'b1, 2'b01);

        // 5. consecutive sweep of all lanes
        for (int k = 0; k < 4; k++) begin
            step($sformatf("sweep_s%0d", k), 1'b0, 1'b1, 2'(k));
            checks++;
            assert ($countones(bus.O) <= 1)
            else begin
                errors++;
                $error("FAIL sweep_onehot_s%0d: observed=%b expected=at most one bit set",
                       k, bus.O);
            end
        end

        // 6. reset mid-stream while lane 3 is active, then release
        step("mid_lane3", 1'b0, 1'b1, 2'b11);
        step("mid_reset", 1'b1, 1'b1, 2'b11);
        step("post_reset_lane1", 1'b0, 1'b1, 2'b01);

        // Random traffic with occasional reset pulses
        for (int n = 0; n < 80; n++) begin
            r = ($urandom_range(0, 9) == 0);
            i = 1'($urandom());
            s = 2'($urandom());
            exp = model(r, i, s);
            step($sformatf("rand%0d_r%0d_i%0d_s%0d", n, r, i, s), r, i, s);
            checks++;
            assert ((exp == 4'b0000) || (bus.O[s] === 1'b1))
            else begin
                errors++;
                $error("FAIL rand%0d_lane: observed=%b expected lane %0d set", n, bus.O, s);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors=%0d of %0d checks",
                 errors, checks);
        $fatal(1, "timeout");
    end

endmodule
